// File: rtl/dsram_pkg.sv
// Shared constants for the dsram responder: lane geometry, legal read latencies
// and the index-width helper.
package dsram_pkg;

    localparam int unsigned LaneW      = 8;
    localparam int unsigned NumLanes   = 4;
    localparam int unsigned ReadLatMin = 1;
    localparam int unsigned ReadLatMax = 3;

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(val)) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/dsram_array.sv
// Single-port word array with per-lane write enables and a registered read port.
// Storage is never reset; only the read register is.
module dsram_array
    import dsram_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned IDX_W = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                rd_en,
    input  logic [NumLanes-1:0] we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NumLanes; i++) begin
            if (we[i]) begin
                mem[idx][i*LaneW +: LaneW] <= wdata[i*LaneW +: LaneW];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dsram_responder.sv
// SRAM responder for the CPU sram_* interface: address decode, read-latency pipeline,
// sticky out-of-range flag. Define DSRAM_ACCESS_CNT_EN to add rd_cnt/wr_cnt counters.
module dsram_responder
    import dsram_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned READ_LAT  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
`ifdef DSRAM_ACCESS_CNT_EN
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
`endif
    output logic        oor_err
);

    localparam int unsigned IdxW   = clog2(DEPTH);
    localparam logic [29:0] DepthW = 30'(DEPTH);

    if (READ_LAT < ReadLatMin || READ_LAT > ReadLatMax) begin : g_bad_lat
        $error("dsram_responder: READ_LAT must be within 1..3");
    end

    logic [31:0] off;
    logic        in_range;
    logic        acc_ok;
    logic        rd_req;
    logic        rd_hit;
    logic [31:0] arr_rdata;
    logic        rd_oor_q;
    logic [31:0] stage1;
    logic        unused_off;

    assign off        = sram_addr - BASE_ADDR;
    assign in_range   = (sram_addr >= BASE_ADDR) && (off[31:2] < DepthW);
    assign acc_ok     = sram_en && in_range;
    assign rd_req     = sram_en && (sram_wen == 4'b0000);
    assign rd_hit     = rd_req && in_range;
    assign unused_off = ^off[1:0];

    dsram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IdxW)
    ) u_array (
        .clk    (clk),
        .resetn (resetn),
        .rd_en  (rd_hit),
        .we     (sram_wen & {NumLanes{acc_ok}}),
        .idx    (off[IdxW+1:2]),
        .wdata  (sram_wdata),
        .rdata  (arr_rdata)
    );

    // rd_oor_q tags the word held in the array read register; out-of-range reads yield zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oor_err  <= 1'b0;
            rd_oor_q <= 1'b0;
        end else begin
            if (sram_en && !in_range) begin
                oor_err <= 1'b1;
            end
            if (rd_req) begin
                rd_oor_q <= !in_range;
            end
        end
    end

    assign stage1 = rd_oor_q ? 32'h0 : arr_rdata;

    if (READ_LAT <= 1) begin : g_lat1
        assign sram_rdata = stage1;
    end else begin : g_latn
        logic [READ_LAT-2:0] vld_q;
        logic [31:0]         pipe_q [READ_LAT-1];

        // Stages only load on a valid result so the output holds between reads.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                vld_q <= '0;
                for (int k = 0; k < int'(READ_LAT) - 1; k++) begin
                    pipe_q[k] <= '0;
                end
            end else begin
                vld_q[0] <= rd_req;
                if (vld_q[0]) begin
                    pipe_q[0] <= stage1;
                end
                for (int k = 1; k < int'(READ_LAT) - 1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k]) begin
                        pipe_q[k] <= pipe_q[k-1];
                    end
                end
            end
        end

        assign sram_rdata = pipe_q[READ_LAT-2];
    end

`ifdef DSRAM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_hit) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (acc_ok && sram_wen != 4'b0000) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: three instances (READ_LAT 1, 2, 3) share one stimulus stream;
// a scoreboard of expected read results is consumed by each instance at its own latency.
module tb_dsram_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sram_en = 1'b0;
    logic [3:0]  sram_wen = 4'h0;
    logic [31:0] sram_addr = 32'h0;
    logic [31:0] sram_wdata = 32'h0;
    logic [31:0] rdata1, rdata2, rdata3;
    logic        oor1, oor2, oor3;
`ifdef DSRAM_ACCESS_CNT_EN
    logic [31:0] rdc1, rdc2, rdc3, wrc1, wrc2, wrc3;
`endif

    always #5 clk = ~clk;

    dsram_responder #(.DEPTH(4096), .READ_LAT(1), .BASE_ADDR(32'h0)) u_l1 (
        .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(rdata1),
`ifdef DSRAM_ACCESS_CNT_EN
        .rd_cnt(rdc1), .wr_cnt(wrc1),
`endif
        .oor_err(oor1));

    dsram_responder #(.DEPTH(4096), .READ_LAT(2), .BASE_ADDR(32'h0)) u_l2 (
        .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(rdata2),
`ifdef DSRAM_ACCESS_CNT_EN
        .rd_cnt(rdc2), .wr_cnt(wrc2),
`endif
        .oor_err(oor2));

    dsram_responder #(.DEPTH(4096), .READ_LAT(3), .BASE_ADDR(32'h0)) u_l3 (
        .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(rdata3),
`ifdef DSRAM_ACCESS_CNT_EN
        .rd_cnt(rdc3), .wr_cnt(wrc3),
`endif
        .oor_err(oor3));

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          base;
        logic [31:0] data;
    } sb_t;

    vec_t        tbl[$];
    sb_t         sb[$];
    int          cyc = 0;
    int          ptr [1:3] = '{0, 0, 0};
    logic [31:0] exp_rd [1:3] = '{32'h0, 32'h0, 32'h0};
    logic        exp_oor;
    int          oor_at = -1;
    int          n_rd = 0;
    int          n_wr = 0;
    int          n_total = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) begin
                $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
            end
        end
    endtask

    // Drive one access just after an edge; it is sampled at the next edge.
    task automatic op(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp);
        logic oor;
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = addr;
        sram_wdata = wdata;
        oor        = addr >= 32'h4000;
        if (en) begin
            if (oor && oor_at < 0) oor_at = cyc + 1;
            if (wen == 4'h0) begin
                sb.push_back('{base: cyc, data: oor ? 32'h0 : exp});
                if (!oor) n_rd++;
            end else if (!oor) begin
                n_wr++;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            for (int l = 1; l <= 3; l++) begin
                exp_rd[l] = 32'h0;
                ptr[l]    = sb.size();
            end
        end else begin
            for (int l = 1; l <= 3; l++) begin
                while (ptr[l] < sb.size() && sb[ptr[l]].base + l <= cyc) begin
                    exp_rd[l] = sb[ptr[l]].data;
                    ptr[l]++;
                end
            end
        end
        exp_oor = resetn && oor_at >= 0 && cyc >= oor_at;
        check("rdata_lat1", rdata1, exp_rd[1]);
        check("rdata_lat2", rdata2, exp_rd[2]);
        check("rdata_lat3", rdata3, exp_rd[3]);
        check("oor_lat1", {31'h0, oor1}, {31'h0, exp_oor});
        check("oor_lat2", {31'h0, oor2}, {31'h0, exp_oor});
        check("oor_lat3", {31'h0, oor3}, {31'h0, exp_oor});
    end

    initial begin
        // en, wen, addr, wdata, expected read data
        tbl.push_back('{1'b1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF});
        tbl.push_back('{1'b1, 4'hF, 32'h0000_0080, 32'h1122_3344, 32'h0});
        tbl.push_back('{1'b1, 4'h5, 32'h0000_0080, 32'hAABB_CCDD, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0080, 32'h0,         32'h11BB_33DD});
        tbl.push_back('{1'b1, 4'hF, 32'h0000_0000, 32'h0000_0001, 32'h0});
        tbl.push_back('{1'b1, 4'hF, 32'h0000_0004, 32'h0000_0002, 32'h0});
        tbl.push_back('{1'b1, 4'hF, 32'h0000_0008, 32'h0000_0003, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0000, 32'h0,         32'h0000_0001});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0004, 32'h0,         32'h0000_0002});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0008, 32'h0,         32'h0000_0003});
        tbl.push_back('{1'b0, 4'h0, 32'h0,         32'h0,         32'h0});
        tbl.push_back('{1'b0, 4'h0, 32'h0,         32'h0,         32'h0});
        tbl.push_back('{1'b0, 4'h0, 32'h0,         32'h0,         32'h0});
        tbl.push_back('{1'b1, 4'hF, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_4000, 32'h0,         32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0000, 32'h0,         32'h0000_0001});
        tbl.push_back('{1'b1, 4'hF, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_3FFC, 32'h0,         32'hCAFE_F00D});
        tbl.push_back('{1'b1, 4'h8, 32'h0000_0080, 32'h9900_0000, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0083, 32'h0,         32'h99BB_33DD});
        tbl.push_back('{1'b1, 4'h0, 32'hFFFF_FFFC, 32'h0,         32'h0});
        // Write lands while the previous read of the same word is still in flight.
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF});
        tbl.push_back('{1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h0});
        tbl.push_back('{1'b1, 4'h0, 32'h0000_0040, 32'h0,         32'h1234_5678});

        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            op(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
        end
        idle(4);

        // Reset lands while a read of a nonzero word is still in the pipeline.
        op(1'b1, 4'h0, 32'h0000_0040, 32'h0, 32'h1234_5678);
        resetn  = 1'b0;
        sram_en = 1'b0;
        oor_at  = -1;
        n_rd    = 0;
        n_wr    = 0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        idle(4);

        // Fresh traffic after reset: 5 in-range reads, 3 in-range writes, 2 out of range.
        op(1'b1, 4'h0, 32'h0000_0040, 32'h0,         32'h1234_5678);
        op(1'b1, 4'hF, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0);
        op(1'b1, 4'h0, 32'h0000_0000, 32'h0,         32'h0000_0001);
        op(1'b1, 4'hF, 32'h0000_4000, 32'h5555_5555, 32'h0);
        op(1'b1, 4'h0, 32'h0000_0004, 32'h0,         32'h0000_0002);
        op(1'b1, 4'h3, 32'h0000_0104, 32'h0000_BEEF, 32'h0);
        op(1'b1, 4'h0, 32'h0000_8000, 32'h0,         32'h0);
        op(1'b1, 4'h0, 32'h0000_0008, 32'h0,         32'h0000_0003);
        op(1'b1, 4'hF, 32'h0000_0108, 32'h0BAD_F00D, 32'h0);
        op(1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hA5A5_A5A5);
        idle(5);

`ifdef DSRAM_ACCESS_CNT_EN
        check("rd_cnt_lat1", rdc1, 32'd5);
        check("rd_cnt_lat2", rdc2, 32'd5);
        check("rd_cnt_lat3", rdc3, 32'd5);
        check("wr_cnt_lat1", wrc1, 32'd3);
        check("wr_cnt_lat2", wrc2, 32'd3);
        check("wr_cnt_lat3", wrc3, 32'(n_wr));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Synchronous SRAM responder: the target end of the CPU's `*_sram_en / wen / addr / wdata / rdata` interface.
- Backs either the instruction or the data port in simulation and FPGA builds, in place of a vendor block RAM.
- Accepts one access per cycle with byte-lane write enables.
- Returns read data after a fixed, parameterised latency. The interface has no ready/stall signal.

Parameters:
- DEPTH, 4096: number of 32-bit words stored; power of two.
- READ_LAT, 1: cycles from read request to valid `sram_rdata`; legal values 1..3.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; 4-byte aligned.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- sram_en  input  1  access request this cycle.
- sram_wen  input  4  byte-lane write enables; lane i covers wdata[8i+7:8i]. 4'b0000 with en=1 is a read.
- sram_addr  input  32  byte address; bits [1:0] ignored.
- sram_wdata  input  32  store data, already lane-aligned by the requester.
- sram_rdata  output  32  read data.
- oor_err  output  1  sticky flag; set by any out-of-range access.

Behaviour:
- Reset (async, resetn=0):
  - sram_rdata=0, oor_err=0.
  - Read-latency pipeline and its valid bits cleared.
  - Memory array NOT cleared; contents are undefined after power-up, and no initial-load hook is provided.
- Decode:
  - off = sram_addr - BASE_ADDR, using 32-bit wrap arithmetic.
  - In range iff sram_addr >= BASE_ADDR and off[31:2] < DEPTH.
  - Word index = off[log2(DEPTH)+1:2].
- Write: en=1, wen!=0, in range.
  - At the clock edge, each enabled lane is written; disabled lanes keep their old bytes (read-modify-write merge is internal to the array).
  - Writes do not advance the read pipeline; sram_rdata keeps its previous value.
- Read: en=1, wen=0, in range.
  - Array word captured at the edge, then shifted through a (READ_LAT-1)-deep register chain.
  - sram_rdata is updated exactly READ_LAT rising edges after the request edge.
- Read-after-write:
  - A read issued the cycle after a write to the same word returns the merged new data.
  - A write issued while an earlier read is still in the pipeline does not alter that read's data.
- Back-to-back reads: one result per cycle. Each result is delivered in order and holds until the next valid result replaces it.
- Idle (en=0): no array change; sram_rdata holds its last value.
- Out of range (en=1):
  - Writes are ignored.
  - Reads deliver 32'h0 at the normal latency.
  - oor_err is set on the following edge and stays set until reset.
- Reset mid-operation: in-flight reads are discarded and sram_rdata is forced to 0. The first read after resetn rises follows normal latency.
- Illegal READ_LAT (outside 1..3): elaboration-time error via a generate-block check.

Optional Feature:
- Macro: DSRAM_ACCESS_CNT_EN.
- Defined:
  - Adds output ports rd_cnt[31:0] and wr_cnt[31:0].
  - Each counter increments once per accepted in-range read or write (en=1 and in range). Out-of-range accesses are not counted.
  - Both counters reset to 0 asynchronously and wrap 32'hFFFF_FFFF -> 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package (dsram_pkg) holds:
  - the byte-lane width constant (8);
  - the lane count (4);
  - a localparam function clog2 for index width;
  - the READ_LAT legal range constants.
- Sub-module: one natural split, dsram_array.
  - Single-port word array with per-lane write enable and registered read.
  - Top level keeps decode, latency pipeline, error flag and counters.

Test Plan:
- Word write/read: write wen=4'hF, addr=0x40, wdata=0xDEADBEEF; read 0x40 next cycle -> rdata=0xDEADBEEF exactly READ_LAT edges after the read request; oor_err=0.
- Lane merge: prior word 0x11223344 at 0x80; write wen=4'b0101, wdata=0xAABBCCDD; read 0x80 -> rdata=0x11BB33DD.
- Pipelined reads (READ_LAT=2): addresses 0x0, 0x4, 0x8 on consecutive cycles holding 1, 2, 3 -> rdata shows 1, 2, 3 on edges 2, 3, 4 after the first request; rdata holds 3 while en=0.
- Out of range (DEPTH=4096, BASE=0): write to 0x4000 then read 0x4000 -> rdata=0 at normal latency, oor_err=1 from the next edge; word 0x0 is unchanged.
- Reset mid-read (READ_LAT=3): issue a read of a nonzero word, assert resetn=0 one cycle later -> rdata=0 immediately, no stale data after release; a fresh read returns the correct array value.
- Counters (macro defined): 5 in-range reads, 3 in-range writes, 2 out-of-range accesses -> rd_cnt=5, wr_cnt=3.
